// File: rtl/sdx_kernel_addwm_adder_ctrl.sv
// Control wrapper for the add-with-multiplier adder kernel.
// A host start latches a constant and a beat count. The constant is then held
// stable for a few cycles before the stream opens. A fixed number of beats is
// passed through to the adder with zero latency and tlast is generated on the
// final beat. After that, a one-cycle done pulse is raised.
module sdx_kernel_addwm_adder_ctrl #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_LENGTH_WIDTH     = 32,
  parameter int C_ARM_CYCLES       = 2
) (
  input  logic                            aclk,
  input  logic                            areset,

  input  logic                            ap_start,
  output logic                            ap_idle,
  output logic                            ap_done,

  input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant,
  input  logic [C_LENGTH_WIDTH-1:0]       ctrl_length,
  output logic [C_ADDER_BIT_WIDTH-1:0]    adder_constant,
  output logic [31:0]                     stat_beats,

  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,

  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int ARM_W = (C_ARM_CYCLES > 1) ? $clog2(C_ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0]          ARM_LAST = ARM_W'(C_ARM_CYCLES - 1);
  localparam logic [C_LENGTH_WIDTH-1:0] LEN_ONE  = C_LENGTH_WIDTH'(1);

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [ARM_W-1:0]          arm_cnt;
  logic [C_LENGTH_WIDTH-1:0] beat_cnt;
  logic [C_LENGTH_WIDTH-1:0] length_r;

  logic run_active;
  logic last_beat;
  logic handshake;
  logic start_accept;

  // The stream is open only in RUN. It is also closed while reset is asserted,
  // so a beat presented on the aborting edge is never acknowledged upstream.
  assign run_active   = (state == ST_RUN) && !areset;
  // beat_cnt never exceeds length-1, so a full-scale length cannot overflow it.
  assign last_beat    = (beat_cnt == (length_r - LEN_ONE));
  assign handshake    = run_active && s_axis_tvalid && m_axis_tready;
  assign start_accept = (state == ST_IDLE) && ap_start;

  assign ap_idle = (state == ST_IDLE);
  assign ap_done = (state == ST_DONE);

  // tvalid and tlast depend on state and upstream valid only, never on tready.
  assign m_axis_tvalid = run_active && s_axis_tvalid;
  assign s_axis_tready = run_active && m_axis_tready;
  assign m_axis_tlast  = run_active && last_beat;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;

  // Next-state selection for the job sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (ap_start) begin
          state_nxt = (ctrl_length == '0) ? ST_DONE : ST_ARM;
        end
      end
      ST_ARM: begin
        if (arm_cnt == ARM_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (handshake && last_beat) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arm-period counter: counts ARM cycles, rewinds on exit and in DONE.
  always_ff @(posedge aclk) begin
    if (areset) begin
      arm_cnt <= '0;
    end else if (state == ST_ARM) begin
      if (arm_cnt == ARM_LAST) begin
        arm_cnt <= '0;
      end else begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end
    end else if (state == ST_DONE) begin
      arm_cnt <= '0;
    end
  end

  // Per-job beat counter, advanced on each accepted beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt <= '0;
    end else if (state == ST_DONE) begin
      beat_cnt <= '0;
    end else if (handshake) begin
      beat_cnt <= beat_cnt + LEN_ONE;
    end
  end

  // Job parameters are captured only on an accepted start.
  always_ff @(posedge aclk) begin
    if (areset) begin
      length_r       <= '0;
      adder_constant <= '0;
    end else if (start_accept) begin
      length_r       <= ctrl_length;
      adder_constant <= ctrl_constant;
    end
  end

  // Lifetime beat statistic, saturating at all-ones.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_beats <= '0;
    end else if (handshake && (stat_beats != '1)) begin
      stat_beats <= stat_beats + 32'd1;
    end
  end

endmodule

// File: tb/tb_sdx_kernel_addwm_adder_ctrl.sv
// Bench for sdx_kernel_addwm_adder_ctrl: directed jobs plus randomized jobs.
// Expectations come from a job-level model with a beat list per job, a
// running beat total and the constant last accepted.
module tb_sdx_kernel_addwm_adder_ctrl;

  localparam int DW        = 64;
  localparam int KW        = DW / 8;
  localparam int AW        = 32;
  localparam int LW        = 32;
  localparam int ARM       = 2;
  localparam int RUN_LIMIT = 400;

  logic          aclk = 1'b0;
  logic          areset;
  logic          ap_start;
  logic          ap_idle;
  logic          ap_done;
  logic [AW-1:0] ctrl_constant;
  logic [LW-1:0] ctrl_length;
  logic [AW-1:0] adder_constant;
  logic [31:0]   stat_beats;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  int unsigned   exp_stat = 0;
  logic [AW-1:0] exp_const = '0;

  sdx_kernel_addwm_adder_ctrl #(
    .C_AXIS_TDATA_WIDTH (DW),
    .C_ADDER_BIT_WIDTH  (AW),
    .C_LENGTH_WIDTH     (LW),
    .C_ARM_CYCLES       (ARM)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .ap_start       (ap_start),
    .ap_idle        (ap_idle),
    .ap_done        (ap_done),
    .ctrl_constant  (ctrl_constant),
    .ctrl_length    (ctrl_length),
    .adder_constant (adder_constant),
    .stat_beats     (stat_beats),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One job from the IDLE cycle in which start is presented to the IDLE cycle
  // after DONE (or after an abort). mode: 0 sink always ready, 1 ready
  // pattern 1,0,0 repeating, 2 random valid and ready.
  task automatic run_job(input logic [AW-1:0] k, input int unsigned len, input int mode,
                         input bit late_k, input logic [AW-1:0] k_late,
                         input int abort_at, input bit hold);
    logic [DW-1:0] dq [$];
    logic [KW-1:0] kq [$];
    int unsigned sent = 0;
    int unsigned cyc  = 0;
    int unsigned r    = 0;
    bit cur_valid     = 1'b0;
    bit rdy           = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      dq.push_back({$urandom, $urandom});
      kq.push_back(KW'($urandom));
    end

    ctrl_constant = k;
    ctrl_length   = LW'(len);
    ap_start      = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    chk("start_idle", ap_idle, 1);
    chk("start_tvalid", m_axis_tvalid, 0);
    tick();
    exp_const = k;
    ap_start  = hold;
    if (!hold) begin
      ctrl_constant = $urandom;
      ctrl_length   = $urandom;
    end

    if (len == 0) begin
      #1;
      chk("zl_done", ap_done, 1);
      chk("zl_tvalid", m_axis_tvalid, 0);
      chk("zl_tready", s_axis_tready, 0);
      chk("zl_const", adder_constant, exp_const);
      tick();
      chk("zl_done_clr", ap_done, 0);
      chk("zl_idle", ap_idle, 1);
      return;
    end

    for (int i = 0; i < ARM; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = dq[0];
      s_axis_tkeep  = kq[0];
      m_axis_tready = 1'b1;
      if (!hold) ap_start = 1'($urandom_range(0, 1));
      #1;
      chk("arm_tvalid", m_axis_tvalid, 0);
      chk("arm_tready", s_axis_tready, 0);
      chk("arm_tlast", m_axis_tlast, 0);
      chk("arm_idle", ap_idle, 0);
      chk("arm_done", ap_done, 0);
      chk("arm_const", adder_constant, exp_const);
      tick();
    end

    cur_valid = 1'b1;
    while (sent < len && cyc < RUN_LIMIT) begin
      if (!cur_valid) cur_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((r % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      s_axis_tvalid = cur_valid;
      s_axis_tdata  = dq[sent];
      s_axis_tkeep  = kq[sent];
      m_axis_tready = rdy;
      if (late_k) ctrl_constant = k_late;
      if (!hold) ap_start = 1'($urandom_range(0, 1));

      if (abort_at >= 0 && int'(sent) == abort_at) begin
        areset        = 1'b1;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        #1;
        chk("abort_tready", s_axis_tready, 0);
        chk("abort_tvalid", m_axis_tvalid, 0);
        tick();
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        ap_start      = 1'b0;
        exp_stat      = 0;
        exp_const     = '0;
        #1;
        chk("abort_idle", ap_idle, 1);
        chk("abort_done", ap_done, 0);
        chk("abort_beat_cnt", dut.beat_cnt, 0);
        chk("abort_stat", stat_beats, exp_stat);
        chk("abort_const", adder_constant, exp_const);
        tick();
        chk("abort_no_done", ap_done, 0);
        return;
      end

      #1;
      chk("run_tvalid", m_axis_tvalid, cur_valid);
      chk("run_tready", s_axis_tready, rdy);
      chk("run_tdata", m_axis_tdata, dq[sent]);
      chk("run_tkeep", m_axis_tkeep, kq[sent]);
      chk("run_tlast", m_axis_tlast, (sent == len - 1));
      chk("run_const", adder_constant, exp_const);
      chk("run_done", ap_done, 0);
      tick();
      if (cur_valid && rdy) begin
        sent++;
        exp_stat++;
        cur_valid = 1'b0;
      end
      r++;
      cyc++;
    end
    chk("run_beats", sent, len);

    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    if (!hold) ap_start = 1'b0;
    #1;
    chk("done_pulse", ap_done, 1);
    chk("done_tvalid", m_axis_tvalid, 0);
    chk("done_tready", s_axis_tready, 0);
    chk("done_tlast", m_axis_tlast, 0);
    chk("done_stat", stat_beats, exp_stat);
    chk("done_const", adder_constant, exp_const);
    tick();
    chk("post_done_clr", ap_done, 0);
    chk("post_idle", ap_idle, 1);
    chk("post_beat_cnt", dut.beat_cnt, 0);
  endtask

  initial begin
    areset        = 1'b1;
    ap_start      = 1'b0;
    ctrl_constant = '0;
    ctrl_length   = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    m_axis_tready = 1'b0;
    tick();
    tick();
    areset        = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_stat", stat_beats, 0);
    chk("rst_const", adder_constant, 0);
    chk("rst_beat_cnt", dut.beat_cnt, 0);
    tick();

    // Basic job: constant 5, four beats, sink always ready.
    run_job(32'd5, 4, 0, 1'b0, '0, -1, 1'b0);
    // Zero-length job completes immediately.
    run_job(32'd7, 0, 0, 1'b0, '0, -1, 1'b0);
    // Stalling sink: ready 1,0,0,1,...
    run_job(32'd11, 3, 1, 1'b0, '0, -1, 1'b0);
    // Constant changes to 9 mid-job; the latched 5 must persist.
    run_job(32'd5, 4, 2, 1'b1, 32'd9, -1, 1'b0);
    run_job(32'd9, 1, 0, 1'b0, '0, -1, 1'b0);
    // Reset after two of eight beats, then a clean eight-beat job.
    run_job(32'd3, 8, 0, 1'b0, '0, 2, 1'b0);
    run_job(32'd4, 8, 0, 1'b0, '0, -1, 1'b0);
    // Start held high across two back-to-back jobs.
    run_job(32'd6, 2, 0, 1'b0, '0, -1, 1'b1);
    run_job(32'd6, 2, 0, 1'b0, '0, -1, 1'b0);

    // Reset wins over a simultaneous start.
    ap_start      = 1'b1;
    ctrl_length   = 32'd5;
    ctrl_constant = 32'hABCD;
    areset        = 1'b1;
    tick();
    areset    = 1'b0;
    ap_start  = 1'b0;
    exp_const = '0;
    exp_stat  = 0;
    #1;
    chk("prio_idle", ap_idle, 1);
    chk("prio_const", adder_constant, exp_const);
    chk("prio_stat", stat_beats, exp_stat);
    tick();
    chk("prio_still_idle", ap_idle, 1);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      run_job($urandom, $urandom_range(0, 6), 2, 1'($urandom_range(0, 1)), $urandom, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdx_kernel_addwm_adder_ctrl.md
SDX_KERNEL_ADDWM_ADDER_CTRL -- requirements
Module: sdx_kernel_addwm_adder_ctrl

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 512: stream data width, a multiple of 8.
REQ-002 SHALL have parameter C_ADDER_BIT_WIDTH, default 32: width of the constant fed to the adder.
REQ-003 SHALL have parameter C_LENGTH_WIDTH, default 32: width of the beat-count command.
REQ-004 SHALL have parameter C_ARM_CYCLES, default 2, legal range >= 1: cycles the constant is held stable before the stream opens.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port ap_start, input, 1 bit: start request, sampled only in IDLE.
REQ-008 SHALL have port ap_idle, output, 1 bit: high while in IDLE.
REQ-009 SHALL have port ap_done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port ctrl_constant, input, C_ADDER_BIT_WIDTH bits: constant for the next job.
REQ-011 SHALL have port ctrl_length, input, C_LENGTH_WIDTH bits: beats in the next job.
REQ-012 SHALL have port adder_constant, output, C_ADDER_BIT_WIDTH bits: latched constant driven to the adder.
REQ-013 SHALL have port stat_beats, output, 32 bits: saturating count of all beats delivered since reset.
REQ-014 SHALL have upstream ports s_axis_tvalid (in, 1), s_axis_tready (out, 1), s_axis_tdata (in, C_AXIS_TDATA_WIDTH) and s_axis_tkeep (in, C_AXIS_TDATA_WIDTH/8); there is no upstream tlast.
REQ-015 SHALL have adder-side ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tdata (out, C_AXIS_TDATA_WIDTH), m_axis_tkeep (out, C_AXIS_TDATA_WIDTH/8) and m_axis_tlast (out, 1).

Function
REQ-016 SHALL implement the states IDLE, ARM, RUN and DONE, encoded as a registered state machine.
REQ-017 IDLE: while ap_start=1, SHALL latch ctrl_constant into adder_constant and ctrl_length into the length register on the same edge.
REQ-018 IDLE: while ap_start=1, SHALL go to DONE if ctrl_length=0, otherwise to ARM.
REQ-019 IDLE: while ap_start=0, SHALL stay in IDLE.
REQ-020 ARM: SHALL remain for exactly C_ARM_CYCLES cycles, counted by arm_cnt, then go to RUN.
REQ-021 ARM: SHALL hold m_axis_tvalid=0 and s_axis_tready=0.
REQ-022 RUN: SHALL drive m_axis_tvalid=s_axis_tvalid and s_axis_tready=m_axis_tready combinationally.
REQ-023 RUN: SHALL drive m_axis_tdata=s_axis_tdata and m_axis_tkeep=s_axis_tkeep, giving zero added latency.
REQ-024 RUN: SHALL increment beat_cnt on each m_axis_tvalid and m_axis_tready handshake.
REQ-025 RUN: SHALL assert m_axis_tlast exactly when beat_cnt = length-1.
REQ-026 RUN: SHALL go to DONE on the handshake that carries m_axis_tlast=1.
REQ-027 DONE: SHALL assert ap_done=1 for exactly one cycle, then go to IDLE.
REQ-028 DONE: SHALL clear beat_cnt and arm_cnt.
REQ-029 In every state other than RUN, SHALL hold m_axis_tvalid=0, s_axis_tready=0 and m_axis_tlast=0.
REQ-030 SHALL ignore ap_start outside IDLE; a held ap_start SHALL restart a job on the first IDLE cycle after DONE.
REQ-031 SHALL keep adder_constant stable from the latch edge until the next accepted start.
REQ-032 SHALL ignore changes on ctrl_constant and ctrl_length after the latch edge.
REQ-033 SHALL keep m_axis_tdata, m_axis_tkeep and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0, provided upstream obeys AXI-Stream.
REQ-034 SHALL increment stat_beats by 1 per handshake, saturating at 0xFFFFFFFF with no wrap.
REQ-035 SHALL treat the length register as unsigned; a length of 2^C_LENGTH_WIDTH-1 SHALL complete without beat_cnt overflow.
REQ-036 SHALL NOT combinationally depend m_axis_tvalid or m_axis_tlast on m_axis_tready.

Reset
REQ-037 On an aclk edge with areset=1, SHALL set state to IDLE and beat_cnt, arm_cnt, the length register, adder_constant and stat_beats to 0.
REQ-038 SHALL give outputs the reset values ap_idle=1, ap_done=0, m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0.
REQ-039 Reset asserted in ARM or RUN SHALL abort the job with no ap_done pulse, leaving in-flight upstream data unacknowledged.
REQ-040 Reset SHALL take priority over ap_start in the same cycle.

Verification
REQ-041 Bench SHALL cover: ctrl_constant=5, ctrl_length=4, ap_start pulse, sink always ready -> 2 ARM cycles with tvalid=0, then 4 beats, tlast on beat 4, ap_done 1 cycle later, stat_beats=4.
REQ-042 Bench SHALL cover: ctrl_length=0, ap_start -> next cycle ap_done=1, no m_axis_tvalid, adder_constant updated.
REQ-043 Bench SHALL cover: ctrl_length=3, m_axis_tready toggling 1,0,0,1,... -> data held during stalls, exactly 3 handshakes, tlast only on the third.
REQ-044 Bench SHALL cover: ctrl_constant changed from 5 to 9 during RUN -> adder_constant stays 5 until the next start.
REQ-045 Bench SHALL cover: areset pulsed after 2 of 8 beats -> ap_idle=1, beat_cnt=0, stat_beats=0, no ap_done; a new job with length 8 then completes normally.
REQ-046 Bench SHALL cover: ap_start held high across two jobs of length 2 -> back-to-back jobs with exactly one IDLE cycle between DONE and ARM.
